// File: rtl/rs_issue_bank_pkg.sv
// rtl/rs_issue_bank_pkg.sv - shared types, sizes and the operand wakeup helper
//   Types:  control_bits, cdb {tag, value}, rs_entry (one reservation station)
//   Consts: RS_SIZE, ROB_SIZE, TAG_W, DATA_W, AGE_W, RS_IDX_W, NO_TAG, AGE_MAX
package rs_issue_bank_pkg;

  localparam int RS_SIZE  = 8;
  localparam int ROB_SIZE = 64;
  localparam int TAG_W    = $clog2(ROB_SIZE);
  localparam int DATA_W   = 32;
  localparam int AGE_W    = 4;
  localparam int RS_IDX_W = $clog2(RS_SIZE);

  localparam logic [TAG_W-1:0] NO_TAG  = '0;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef struct packed {
    logic [3:0] alu_op;
    logic [1:0] fu_sel;
    logic       use_imm;
    logic       is_branch;
  } control_bits;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } cdb;

  typedef struct packed {
    logic              busy;
    control_bits       ctrl_bits;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value_1;
    logic [DATA_W-1:0] value_2;
    logic [TAG_W-1:0]  tag_1;
    logic [TAG_W-1:0]  tag_2;
    logic [DATA_W-1:0] imm;
  } rs_entry;

  // Resolve any operand whose pending tag is broadcast on a CDB.
  // An operand with a pending tag never matches an idle (tag 0) CDB,
  // since its own tag is nonzero. cdb1 wins when both CDBs match.
  function automatic rs_entry wake_entry(rs_entry e, cdb c1, cdb c2);
    rs_entry r;
    r = e;
    if (e.tag_1 != NO_TAG) begin
      if (c1.tag == e.tag_1) begin
        r.value_1 = c1.value;
        r.tag_1   = NO_TAG;
      end else if (c2.tag == e.tag_1) begin
        r.value_1 = c2.value;
        r.tag_1   = NO_TAG;
      end
    end
    if (e.tag_2 != NO_TAG) begin
      if (c1.tag == e.tag_2) begin
        r.value_2 = c1.value;
        r.tag_2   = NO_TAG;
      end else if (c2.tag == e.tag_2) begin
        r.value_2 = c2.value;
        r.tag_2   = NO_TAG;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_issue_bank_oldest_select.sv
// rtl/rs_issue_bank_oldest_select.sv - pick the oldest ready station (rs_oldest_select)
//   ready_i : per-station ready flags
//   age_i   : per-station age counters
//   idx_o   : index of the ready station with maximum age, lowest index on ties; 0 if none
//   valid_o : any station ready
module rs_oldest_select #(
  parameter int RS_SIZE = 8,
  parameter int AGE_W   = 4,
  localparam int IDX_W  = $clog2(RS_SIZE)
) (
  input  logic [RS_SIZE-1:0]            ready_i,
  input  logic [RS_SIZE-1:0][AGE_W-1:0] age_i,
  output logic [IDX_W-1:0]              idx_o,
  output logic                          valid_o
);

  logic [AGE_W-1:0] best_age;

  // Strict '>' keeps the earlier (lower) index when ages tie.
  always_comb begin
    idx_o    = '0;
    valid_o  = 1'b0;
    best_age = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (ready_i[i] && (!valid_o || (age_i[i] > best_age))) begin
        valid_o  = 1'b1;
        idx_o    = IDX_W'(i);
        best_age = age_i[i];
      end
    end
  end

endmodule

// File: rtl/rs_issue_bank.sv
// rtl/rs_issue_bank.sv - reservation-station array with CDB wakeup and oldest-ready issue
//   clk, reset (sync, active-low)
//   alloc_valid/alloc_id/alloc_entry : write one station per cycle
//   cdb1, cdb2                       : result broadcasts, tag 0 = idle
//   flush                            : squash all stations
//   res_stations, rs_full            : registered array and all-busy flag
//   issue_valid/issue_entry/issue_id : oldest ready station, accepted on issue_ready
module rs_issue_bank
  import rs_issue_bank_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         alloc_valid,
  input  logic [RS_IDX_W-1:0]          alloc_id,
  input  rs_entry                      alloc_entry,
  input  cdb                           cdb1,
  input  cdb                           cdb2,
  input  logic                         flush,
  output rs_entry [RS_SIZE-1:0]        res_stations,
  output logic                         rs_full,
  output logic                         issue_valid,
  output rs_entry                      issue_entry,
  output logic [RS_IDX_W-1:0]          issue_id,
  input  logic                         issue_ready
);

  rs_entry [RS_SIZE-1:0]            ent_q, ent_d;
  logic [RS_SIZE-1:0][AGE_W-1:0]    age_q, age_d;
  rs_entry                          woken [RS_SIZE];
  rs_entry                          alloc_woken;
  logic [RS_SIZE-1:0]               busy_vec;
  logic [RS_SIZE-1:0]               ready_vec;
  logic [RS_IDX_W-1:0]              sel_idx;
  logic                             sel_valid;
  logic                             issue_fire;

  // Per-station wakeup against both CDBs.
  genvar g;
  generate
    for (g = 0; g < RS_SIZE; g++) begin : g_wake
      assign woken[g]     = wake_entry(ent_q[g], cdb1, cdb2);
      assign busy_vec[g]  = ent_q[g].busy;
      assign ready_vec[g] = ent_q[g].busy && (ent_q[g].tag_1 == NO_TAG)
                                          && (ent_q[g].tag_2 == NO_TAG);
    end
  endgenerate

  // The incoming entry snoops the same broadcasts so a result seen in the
  // allocate cycle is not lost.
  assign alloc_woken = wake_entry(alloc_entry, cdb1, cdb2);

  rs_oldest_select #(
    .RS_SIZE (RS_SIZE),
    .AGE_W   (AGE_W)
  ) u_select (
    .ready_i (ready_vec),
    .age_i   (age_q),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  assign issue_valid  = sel_valid;
  assign issue_id     = sel_idx;
  assign issue_entry  = sel_valid ? ent_q[sel_idx] : '0;
  assign issue_fire   = sel_valid && issue_ready;
  assign rs_full      = &busy_vec;
  assign res_stations = ent_q;

  // Priority, lowest to highest: wakeup/aging, issue, allocation, flush.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      ent_d[i] = ent_q[i];
      age_d[i] = age_q[i];
      if (ent_q[i].busy) begin
        ent_d[i] = woken[i];
        if (age_q[i] != AGE_MAX) begin
          age_d[i] = age_q[i] + AGE_W'(1);
        end
      end
      if (issue_fire && (sel_idx == RS_IDX_W'(i))) begin
        ent_d[i].busy = 1'b0;
        age_d[i]      = '0;
      end
      if (alloc_valid && (alloc_id == RS_IDX_W'(i))) begin
        ent_d[i] = alloc_woken;
        age_d[i] = '0;
      end
      if (flush) begin
        ent_d[i].busy = 1'b0;
        age_d[i]      = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ent_q <= '0;
      age_q <= '0;
    end else begin
      ent_q <= ent_d;
      age_q <= age_d;
    end
  end

  // Writing a busy station is a scheduler bug, unless that station is being
  // issued in the same cycle or a flush discards the write.
  a_no_alloc_into_busy: assert property (
    @(posedge clk) disable iff (!reset)
    (alloc_valid && !flush && ent_q[alloc_id].busy) |-> (issue_fire && (sel_idx == alloc_id))
  );

endmodule

// File: tb/tb_rs_issue_bank.sv
// tb/tb_rs_issue_bank.sv - scoreboard bench for rs_issue_bank
module tb_rs_issue_bank;
  import rs_issue_bank_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset = 1'b0;
  logic                  alloc_valid = 1'b0;
  logic [RS_IDX_W-1:0]   alloc_id = '0;
  rs_entry               alloc_entry = '0;
  cdb                    cdb1 = '0;
  cdb                    cdb2 = '0;
  logic                  flush = 1'b0;
  logic                  issue_ready = 1'b0;
  rs_entry [RS_SIZE-1:0] res_stations;
  logic                  rs_full;
  logic                  issue_valid;
  rs_entry               issue_entry;
  logic [RS_IDX_W-1:0]   issue_id;

  rs_issue_bank dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_valid  (alloc_valid),
    .alloc_id     (alloc_id),
    .alloc_entry  (alloc_entry),
    .cdb1         (cdb1),
    .cdb2         (cdb2),
    .flush        (flush),
    .res_stations (res_stations),
    .rs_full      (rs_full),
    .issue_valid  (issue_valid),
    .issue_entry  (issue_entry),
    .issue_id     (issue_id),
    .issue_ready  (issue_ready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                id;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [TAG_W-1:0]  tag;
    int                cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic rs_entry mk(input int tag, input int t1, input int t2,
                                 input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
    rs_entry e;
    e         = '0;
    e.busy    = 1'b1;
    e.tag     = TAG_W'(tag);
    e.tag_1   = TAG_W'(t1);
    e.tag_2   = TAG_W'(t2);
    e.value_1 = v1;
    e.value_2 = v2;
    return e;
  endfunction

  task automatic alloc(input int id, input rs_entry e);
    alloc_valid = 1'b1;
    alloc_id    = RS_IDX_W'(id);
    alloc_entry = e;
  endtask

  task automatic sb_push(input int id, input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2,
                         input int tag, input int at_cyc);
    exp_t e;
    e.id  = id;
    e.v1  = v1;
    e.v2  = v2;
    e.tag = TAG_W'(tag);
    e.cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  function automatic logic [RS_SIZE-1:0] busy_mask();
    logic [RS_SIZE-1:0] m;
    for (int i = 0; i < RS_SIZE; i++) m[i] = res_stations[i].busy;
    return m;
  endfunction

  // Monitor: every accepted issue is matched against the oldest expectation.
  always @(negedge clk) begin
    if (reset && issue_valid && issue_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_issue: id %0d issued at cycle %0d, none required", issue_id, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_id",    64'(issue_id), 64'(e.id));
        check("issue_v1",    64'(issue_entry.value_1), 64'(e.v1));
        check("issue_v2",    64'(issue_entry.value_2), 64'(e.v2));
        check("issue_tag",   64'(issue_entry.tag), 64'(e.tag));
        check("issue_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    // Reset state
    tick();
    tick();
    check("reset_busy",        64'(busy_mask()), 64'd0);
    check("reset_issue_valid", 64'(issue_valid), 64'd0);
    check("reset_rs_full",     64'(rs_full), 64'd0);
    check("reset_issue_id",    64'(issue_id), 64'd0);
    check("reset_issue_entry", 64'(|issue_entry), 64'd0);
    reset = 1'b1;
    issue_ready = 1'b1;

    // Ready at allocation: issues the next cycle, then the slot is freed
    alloc(2, mk(5, 0, 0, 32'd3, 32'd4));
    sb_push(2, 32'd3, 32'd4, 5, cyc + 1);
    tick();
    alloc_valid = 1'b0;
    tick();
    check("t1_slot2_freed", 64'(res_stations[2].busy), 64'd0);

    // Wakeup from cdb2
    alloc(0, mk(9, 7, 0, 32'd0, 32'h22));
    tick();
    alloc_valid = 1'b0;
    check("t2_not_ready", 64'(issue_valid), 64'd0);
    cdb2.tag = TAG_W'(7);
    cdb2.value = 32'hDEAD;
    sb_push(0, 32'hDEAD, 32'h22, 9, cyc + 1);
    tick();
    cdb2 = '0;
    check("t2_value_1", 64'(res_stations[0].value_1), 64'hDEAD);
    check("t2_tag_1",   64'(res_stations[0].tag_1), 64'd0);
    tick();

    // Allocate-cycle wakeup, both CDBs match, cdb1 wins
    alloc(1, mk(10, 0, 3, 32'h11, 32'd0));
    cdb1.tag = TAG_W'(3);
    cdb1.value = 32'h10;
    cdb2.tag = TAG_W'(3);
    cdb2.value = 32'h99;
    sb_push(1, 32'h11, 32'h10, 10, cyc + 1);
    tick();
    alloc_valid = 1'b0;
    cdb1 = '0;
    cdb2 = '0;
    check("t3_tag_2",   64'(res_stations[1].tag_2), 64'd0);
    check("t3_value_2", 64'(res_stations[1].value_2), 64'h10);
    tick();

    // Oldest first: slot 4 (age 3) beats slot 1 (age 1), held under back-pressure
    issue_ready = 1'b0;
    alloc(4, mk(12, 0, 0, 32'd4, 32'h44));
    tick();
    alloc_valid = 1'b0;
    tick();
    alloc(1, mk(13, 0, 0, 32'd1, 32'h11));
    tick();
    alloc_valid = 1'b0;
    tick();
    check("t4_valid", 64'(issue_valid), 64'd1);
    check("t4_hold0", 64'(issue_id), 64'd4);
    tick();
    check("t4_hold1", 64'(issue_id), 64'd4);
    tick();
    check("t4_hold2", 64'(issue_id), 64'd4);
    issue_ready = 1'b1;
    sb_push(4, 32'd4, 32'h44, 12, cyc);
    sb_push(1, 32'd1, 32'h11, 13, cyc + 1);
    tick();
    tick();
    check("t4_drained", 64'(busy_mask()), 64'd0);

    // Issue and reallocate the same slot in one cycle: allocation wins
    alloc(5, mk(20, 0, 0, 32'd1, 32'd2));
    sb_push(5, 32'd1, 32'd2, 20, cyc + 1);
    tick();
    alloc(5, mk(21, 0, 0, 32'd7, 32'd8));
    sb_push(5, 32'd7, 32'd8, 21, cyc + 1);
    tick();
    alloc_valid = 1'b0;
    check("t5_reuse_busy", 64'(res_stations[5].busy), 64'd1);
    check("t5_reuse_tag",  64'(res_stations[5].tag), 64'd21);
    tick();
    check("t5_freed", 64'(res_stations[5].busy), 64'd0);

    // Fill, then flush (flush beats a same-cycle allocation)
    issue_ready = 1'b0;
    for (int i = 0; i < RS_SIZE; i++) begin
      alloc(i, mk(30 + i, 0, 0, DATA_W'(i), DATA_W'(i)));
      tick();
      if (i == RS_SIZE - 2) check("t6_not_full_7", 64'(rs_full), 64'd0);
    end
    alloc_valid = 1'b0;
    check("t6_full", 64'(rs_full), 64'd1);
    flush = 1'b1;
    alloc(3, mk(40, 0, 0, 32'd5, 32'd5));
    tick();
    flush = 1'b0;
    alloc_valid = 1'b0;
    check("t6_flush_busy",  64'(busy_mask()), 64'd0);
    check("t6_flush_full",  64'(rs_full), 64'd0);
    check("t6_flush_valid", 64'(issue_valid), 64'd0);

    // Reset mid-stream with busy entries and a pending allocation
    for (int i = 0; i < 3; i++) begin
      alloc(i, mk(50 + i, 9, 0, 32'd0, 32'd0));
      tick();
    end
    alloc_valid = 1'b0;
    check("t7_three_busy", 64'(busy_mask()), 64'h7);
    reset = 1'b0;
    alloc(6, mk(52, 0, 0, 32'd1, 32'd1));
    tick();
    alloc_valid = 1'b0;
    check("t7_busy",     64'(busy_mask()), 64'd0);
    check("t7_valid",    64'(issue_valid), 64'd0);
    check("t7_full",     64'(rs_full), 64'd0);
    check("t7_issue_id", 64'(issue_id), 64'd0);
    reset = 1'b1;
    tick();
    tick();

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
